// File: rtl/player_ctrl_pkg.sv
// Shared types and aim decode for the player position/aim controller.
package player_ctrl_pkg;

  localparam int unsigned AIM_W  = 3;
  localparam int unsigned STEP_W = 5;

  typedef struct packed {
    logic              dir;
    logic [STEP_W-1:0] run;
    logic [STEP_W-1:0] rise;
  } aim_vec_t;

  // Map an aim index to its {dir, run, rise} vector, symmetric about the centre index.
  function automatic aim_vec_t aim_lut(input logic [AIM_W-1:0] idx, input int unsigned steps);
    aim_vec_t         v;
    logic [AIM_W-1:0] centre;
    logic [AIM_W-1:0] mag;
    centre = AIM_W'((steps - 1) / 2);
    v.dir  = (idx > centre);
    mag    = v.dir ? (idx - centre) : (centre - idx);
    case (mag)
      AIM_W'(0): begin v.run = STEP_W'(0); v.rise = STEP_W'(1); end
      AIM_W'(1): begin v.run = STEP_W'(1); v.rise = STEP_W'(2); end
      AIM_W'(2): begin v.run = STEP_W'(1); v.rise = STEP_W'(1); end
      default:   begin v.run = STEP_W'(2); v.rise = STEP_W'(1); end
    endcase
    return v;
  endfunction

endpackage

// File: rtl/player_ctrl_if.sv
// Shot handshake bus from the player controller to the projectile logic.
interface player_ctrl_if #(
  parameter int unsigned X_W = 5
);
  import player_ctrl_pkg::*;

  logic              shot_valid;
  logic              shot_ready;
  logic [X_W-1:0]    shot_x;
  logic [STEP_W-1:0] shot_run;
  logic [STEP_W-1:0] shot_rise;
  logic              shot_dir;

  modport master (
    output shot_valid, shot_x, shot_run, shot_rise, shot_dir,
    input  shot_ready
  );

  modport slave (
    input  shot_valid, shot_x, shot_run, shot_rise, shot_dir,
    output shot_ready
  );

endinterface

// File: rtl/player_ctrl_btn_repeat.sv
// Tick-gated press-edge detect with hold-to-repeat for one move button.
module btn_repeat #(
  parameter int unsigned REP_DELAY = 8,
  parameter int unsigned REP_RATE  = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic btn_i,
  input  logic block_i,
  output logic move_c
);

  localparam int unsigned CNT_W  = $clog2(REP_DELAY + 1);
  localparam int unsigned RATE_W = $clog2(REP_RATE + 1);

  logic              prev_q, prev_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RATE_W-1:0] rate_q, rate_d;

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      rate_q <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      rate_q <= rate_d;
    end
  end

  // Hold counter saturates at REP_DELAY; the rate counter then paces repeats.
  always_comb begin
    prev_d = prev_q;
    cnt_d  = cnt_q;
    rate_d = rate_q;
    move_c = 1'b0;
    if (tick) begin
      prev_d = btn_i;
      if (block_i || !btn_i) begin
        cnt_d  = '0;
        rate_d = '0;
      end else if (!prev_q) begin
        cnt_d  = CNT_W'(1);
        rate_d = '0;
        move_c = 1'b1;
      end else if (cnt_q < CNT_W'(REP_DELAY)) begin
        cnt_d  = cnt_q + CNT_W'(1);
        rate_d = '0;
        move_c = (cnt_d == CNT_W'(REP_DELAY));
      end else if (rate_q == RATE_W'(REP_RATE - 1)) begin
        rate_d = '0;
        move_c = 1'b1;
      end else begin
        rate_d = rate_q + RATE_W'(1);
      end
    end
  end

endmodule

// File: rtl/player_ctrl.sv
// Per-player position/aim controller with auto-repeat movement and a cooled-down fire handshake.
module player_ctrl
  import player_ctrl_pkg::*;
#(
  parameter int unsigned X_W       = 5,
  parameter int unsigned X_MIN     = 0,
  parameter int unsigned X_MAX     = 31,
  parameter int unsigned X_RESET   = 15,
  parameter int unsigned WRAP_X    = 0,
  parameter int unsigned AIM_STEPS = 7,
  parameter int unsigned REP_DELAY = 8,
  parameter int unsigned REP_RATE  = 2,
  parameter int unsigned COOLDOWN  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              left_x,
  input  logic              right_x,
  input  logic              left_aim,
  input  logic              right_aim,
  input  logic              fire,
  player_ctrl_if.master     shot,
  output logic [X_W-1:0]    x_pos,
  output logic [STEP_W-1:0] run,
  output logic [STEP_W-1:0] rise,
  output logic              dir,
  output logic              cool_busy
);

  localparam int unsigned COOL_W  = $clog2(COOLDOWN + 2);
  localparam int unsigned AIM_CTR = (AIM_STEPS - 1) / 2;

  logic              move_l, move_r, both_x;
  logic [X_W-1:0]    x_q, x_d;
  logic [AIM_W-1:0]  idx_q, idx_d;
  aim_vec_t          aim_q, aim_d;
  logic              prev_la_q, prev_la_d, prev_ra_q, prev_ra_d, prev_fire_q, prev_fire_d;
  logic              sv_q, sv_d;
  logic [X_W-1:0]    sx_q, sx_d;
  aim_vec_t          saim_q, saim_d;
  logic [COOL_W-1:0] cool_q, cool_d;
  logic              busy_q, busy_d;

  assign both_x = left_x & right_x;

  btn_repeat #(.REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)) u_rep_l (
    .clk(clk), .reset_n(reset_n), .tick(tick), .btn_i(left_x), .block_i(both_x), .move_c(move_l)
  );

  btn_repeat #(.REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)) u_rep_r (
    .clk(clk), .reset_n(reset_n), .tick(tick), .btn_i(right_x), .block_i(both_x), .move_c(move_r)
  );

  // State registers; reset drops any pending shot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q         <= X_W'(X_RESET);
      idx_q       <= AIM_W'(AIM_CTR);
      aim_q       <= '{dir: 1'b0, run: STEP_W'(0), rise: STEP_W'(1)};
      prev_la_q   <= 1'b0;
      prev_ra_q   <= 1'b0;
      prev_fire_q <= 1'b0;
      sv_q        <= 1'b0;
      sx_q        <= '0;
      saim_q      <= '0;
      cool_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      x_q         <= x_d;
      idx_q       <= idx_d;
      aim_q       <= aim_d;
      prev_la_q   <= prev_la_d;
      prev_ra_q   <= prev_ra_d;
      prev_fire_q <= prev_fire_d;
      sv_q        <= sv_d;
      sx_q        <= sx_d;
      saim_q      <= saim_d;
      cool_q      <= cool_d;
      busy_q      <= busy_d;
    end
  end

  // Tick-gated move/aim/fire updates; the handshake is honoured on any cycle.
  always_comb begin
    x_d         = x_q;
    idx_d       = idx_q;
    aim_d       = aim_lut(idx_q, AIM_STEPS);
    prev_la_d   = prev_la_q;
    prev_ra_d   = prev_ra_q;
    prev_fire_d = prev_fire_q;
    sv_d        = sv_q;
    sx_d        = sx_q;
    saim_d      = saim_q;
    cool_d      = cool_q;
    if (tick) begin
      prev_la_d   = left_aim;
      prev_ra_d   = right_aim;
      prev_fire_d = fire;
      if (move_l && !move_r) begin
        if (x_q == X_W'(X_MIN)) x_d = (WRAP_X != 0) ? X_W'(X_MAX) : X_W'(X_MIN);
        else                    x_d = x_q - X_W'(1);
      end else if (move_r && !move_l) begin
        if (x_q == X_W'(X_MAX)) x_d = (WRAP_X != 0) ? X_W'(X_MIN) : X_W'(X_MAX);
        else                    x_d = x_q + X_W'(1);
      end
      if (!(left_aim && right_aim)) begin
        if (left_aim && !prev_la_q && (idx_q != '0))
          idx_d = idx_q - AIM_W'(1);
        else if (right_aim && !prev_ra_q && (idx_q != AIM_W'(AIM_STEPS - 1)))
          idx_d = idx_q + AIM_W'(1);
      end
      if (cool_q != '0) cool_d = cool_q - COOL_W'(1);
      if (fire && !prev_fire_q && !sv_q && !busy_q) begin
        sv_d   = 1'b1;
        sx_d   = x_q;
        saim_d = aim_q;
      end
    end
    if (sv_q && shot.shot_ready) begin
      sv_d   = 1'b0;
      cool_d = COOL_W'(COOLDOWN);
    end
    busy_d = (cool_d != '0);
  end

  assign x_pos           = x_q;
  assign run             = aim_q.run;
  assign rise            = aim_q.rise;
  assign dir             = aim_q.dir;
  assign cool_busy       = busy_q;
  assign shot.shot_valid = sv_q;
  assign shot.shot_x     = sx_q;
  assign shot.shot_run   = saim_q.run;
  assign shot.shot_rise  = saim_q.rise;
  assign shot.shot_dir   = saim_q.dir;

endmodule

// File: tb/tb_player_ctrl.sv
// Directed bench for player_ctrl with a shot scoreboard checked at each handshake.
`timescale 1ns/1ps
module tb_player_ctrl;
  import player_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tick = 1'b0;
  logic left_x = 1'b0, right_x = 1'b0, left_aim = 1'b0, right_aim = 1'b0, fire = 1'b0;
  logic shot_ready = 1'b0;
  logic [4:0] x_pos, run, rise;
  logic dir, cool_busy;
  logic w_left = 1'b0, w_right = 1'b0;
  logic [4:0] w_x, w_run, w_rise;
  logic w_dir, w_busy;

  int checks = 0;
  int failures = 0;

  typedef struct { int x; int run; int rise; int dir; } shot_exp_t;
  shot_exp_t sb_q[$];
  shot_exp_t mon_e;

  player_ctrl_if #(.X_W(5)) shot_if ();
  player_ctrl_if #(.X_W(5)) wshot_if ();
  assign shot_if.shot_ready  = shot_ready;
  assign wshot_if.shot_ready = 1'b0;

  always #5 clk = ~clk;

  player_ctrl #(.X_W(5), .X_MIN(0), .X_MAX(31), .X_RESET(15), .WRAP_X(0),
                .AIM_STEPS(7), .REP_DELAY(8), .REP_RATE(2), .COOLDOWN(16)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .left_x(left_x), .right_x(right_x),
    .left_aim(left_aim), .right_aim(right_aim), .fire(fire), .shot(shot_if),
    .x_pos(x_pos), .run(run), .rise(rise), .dir(dir), .cool_busy(cool_busy)
  );

  player_ctrl #(.X_W(5), .X_MIN(0), .X_MAX(31), .X_RESET(0), .WRAP_X(1),
                .AIM_STEPS(7), .REP_DELAY(8), .REP_RATE(2), .COOLDOWN(16)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .tick(tick), .left_x(w_left), .right_x(w_right),
    .left_aim(1'b0), .right_aim(1'b0), .fire(1'b0), .shot(wshot_if),
    .x_pos(w_x), .run(w_run), .rise(w_rise), .dir(w_dir), .cool_busy(w_busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One tick pulse, then one idle cycle so registered aim outputs have settled.
  task automatic do_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_aim(input string name, input int er, input int ei, input int ed);
    chk({name, "_run"}, run, er);
    chk({name, "_rise"}, rise, ei);
    chk({name, "_dir"}, dir, ed);
  endtask

  // Monitor: every accepted shot must match the oldest expected shot.
  always @(posedge clk) begin
    if (reset_n && shot_if.shot_valid && shot_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL shot_unexpected actual_x=%0d expected=none", shot_if.shot_x);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_shot_x", shot_if.shot_x, mon_e.x);
        chk("sb_shot_run", shot_if.shot_run, mon_e.run);
        chk("sb_shot_rise", shot_if.shot_rise, mon_e.rise);
        chk("sb_shot_dir", shot_if.shot_dir, mon_e.dir);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_x", x_pos, 15);
    chk_aim("rst", 0, 1, 0);
    chk("rst_valid", shot_if.shot_valid, 0);
    chk("rst_busy", cool_busy, 0);
    chk("wrap_rst_x", w_x, 0);
    chk("wrap_rst_run", w_run, 0);
    chk("wrap_rst_rise", w_rise, 1);
    chk("wrap_rst_dir", w_dir, 0);
    chk("wrap_rst_busy", w_busy, 0);

    // Aim: step right from centre, with a one-cycle decode latency check.
    right_aim = 1'b1; do_tick(); right_aim = 1'b0; do_tick();
    chk_aim("aim4", 1, 2, 1);
    right_aim = 1'b1; do_tick(); right_aim = 1'b0; do_tick();
    chk_aim("aim5", 1, 1, 1);
    right_aim = 1'b1;
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    chk_aim("aim6_early", 1, 1, 1);
    @(negedge clk);
    chk_aim("aim6", 2, 1, 1);
    right_aim = 1'b0; do_tick();
    for (int i = 0; i < 2; i++) begin
      right_aim = 1'b1; do_tick(); right_aim = 1'b0; do_tick();
      chk_aim("aim_sat", 2, 1, 1);
    end

    // Hold right: moves on ticks 1, 8, 10, 12, then saturates at 31.
    right_x = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      do_tick();
      chk($sformatf("hold_t%0d", t), x_pos,
          15 + 1 + int'(t >= 8) + int'(t >= 10) + int'(t >= 12));
    end
    repeat (30) do_tick();
    chk("sat_max", x_pos, 31);
    right_x = 1'b0;
    fire = 1'b1; do_tick();
    chk("pre_rst_valid", shot_if.shot_valid, 1);
    fire = 1'b0;

    // Asynchronous reset mid-run.
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_x", x_pos, 15);
    chk_aim("async", 0, 1, 0);
    chk("async_valid", shot_if.shot_valid, 0);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);

    // Move to x=20, aim index 4.
    for (int i = 0; i < 5; i++) begin
      right_x = 1'b1; do_tick(); right_x = 1'b0; do_tick();
    end
    chk("setup_x", x_pos, 20);
    right_aim = 1'b1; do_tick(); right_aim = 1'b0; do_tick();
    chk_aim("setup", 1, 2, 1);

    // Fire and move on the same tick: shot carries the old position.
    fire = 1'b1; right_x = 1'b1;
    sb_q.push_back('{x: 20, run: 1, rise: 2, dir: 1});
    do_tick();
    right_x = 1'b0;
    chk("fire_x_after", x_pos, 21);
    chk("fire_valid", shot_if.shot_valid, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stable_x", shot_if.shot_x, 20);
      chk("stable_run", shot_if.shot_run, 1);
    end
    fire = 1'b0; do_tick();
    fire = 1'b1; do_tick();
    chk("ignored_valid", shot_if.shot_valid, 1);
    chk("ignored_x", shot_if.shot_x, 20);
    fire = 1'b0; do_tick();

    // Handshake, then fire edges on alternate ticks through the cooldown.
    shot_ready = 1'b1;
    @(negedge clk) shot_ready = 1'b0;
    chk("hs_valid", shot_if.shot_valid, 0);
    chk("hs_busy", cool_busy, 1);
    chk("hs_sb_empty", sb_q.size(), 0);
    for (int t = 1; t <= 16; t++) begin
      fire = (t % 2 == 1);
      do_tick();
      chk($sformatf("cool_valid_t%0d", t), shot_if.shot_valid, 0);
      chk($sformatf("cool_busy_t%0d", t), cool_busy, int'(t < 16));
    end
    fire = 1'b1;
    sb_q.push_back('{x: 21, run: 1, rise: 2, dir: 1});
    do_tick();
    fire = 1'b0;
    chk("cool_accept", shot_if.shot_valid, 1);
    shot_ready = 1'b1;
    @(negedge clk) shot_ready = 1'b0;
    chk("hs2_busy", cool_busy, 1);

    // Wrap instance and both-buttons block.
    w_left = 1'b1; do_tick(); w_left = 1'b0; do_tick();
    chk("wrap_min", w_x, 31);
    w_right = 1'b1; do_tick(); w_right = 1'b0; do_tick();
    chk("wrap_max", w_x, 0);
    w_left = 1'b1; w_right = 1'b1; do_tick();
    chk("wrap_both", w_x, 0);
    w_left = 1'b0; w_right = 1'b0;
    left_x = 1'b1; right_x = 1'b1; do_tick();
    chk("both_x", x_pos, 21);
    left_x = 1'b0; right_x = 1'b0; do_tick();

    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
